credit_manager_mp: RTL and testbench



---
 rtl/credit_manager_mp_pkg.sv | 35 +++
 rtl/credit_manager_mp_coin_debouncer.sv | 68 ++++++
 rtl/credit_manager_mp.sv | 177 +++++++++++++++++
 tb/tb_credit_manager_mp.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/credit_manager_mp_pkg.sv
// -----------------------------------------------------------------------------
// credit_pkg
// Shared constants and types for the multi-slot credit manager:
//   CREDIT_W      width of the credit counter
//   MAX_SLOTS     largest supported number of coin slots
//   RGB_W         width of an RGB332 pixel
//   COST_1P/2P    credits charged per game start
//   player_mode_t 1P / 2P selector carried on playerMode
//   db_state_t    debouncer stable-level state
//   startCost()   maps a player mode to its cost
// -----------------------------------------------------------------------------
package credit_pkg;

  localparam int CREDIT_W  = 4;
  localparam int MAX_SLOTS = 4;
  localparam int RGB_W     = 8;

  localparam logic [CREDIT_W-1:0] COST_1P = 4'd1;
  localparam logic [CREDIT_W-1:0] COST_2P = 4'd2;

  typedef enum logic {
    MODE_1P = 1'b0,
    MODE_2P = 1'b1
  } player_mode_t;

  typedef enum logic {
    DB_RELEASED = 1'b0,
    DB_PRESSED  = 1'b1
  } db_state_t;

  function automatic logic [CREDIT_W-1:0] startCost(input player_mode_t mode);
    return (mode == MODE_2P) ? COST_2P : COST_1P;
  endfunction

endpackage

// File: rtl/credit_manager_mp_coin_debouncer.sv
// -----------------------------------------------------------------------------
// coin_debouncer
// Single-slot debouncer for an active-low coin switch. A level change is
// accepted only after DEBOUNCE_CYCLES consecutive samples that differ from the
// current stable level. An accepted press (released -> pressed) produces a
// one-cycle press pulse; a new press needs an accepted release first.
// keyN is expected to be synchronous to clk.
// Ports:
//   clk     system clock
//   resetN  synchronous active-low reset (returns to the released state)
//   keyN    raw active-low coin switch
//   press   one-cycle pulse on each accepted press
// -----------------------------------------------------------------------------
module coin_debouncer
  import credit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic resetN,
  input  logic keyN,
  output logic press
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  db_state_t        state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             differs;
  logic             pressEdge, pressQ;

  // State register
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state  <= DB_RELEASED;
      cnt    <= '0;
      pressQ <= 1'b0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      pressQ <= pressEdge;
    end
  end

  // Next-state: count consecutive samples that disagree with the stable
  // level; any agreeing sample restarts the count.
  always_comb begin
    stateNext = state;
    cntNext   = '0;
    differs   = (state == DB_RELEASED) ? ~keyN : keyN;
    if (differs) begin
      if (cnt == CNT_LAST) begin
        stateNext = (state == DB_RELEASED) ? DB_PRESSED : DB_RELEASED;
      end else begin
        cntNext = cnt + 1'b1;
      end
    end
  end

  // Output: a press is the accepted released -> pressed transition
  always_comb begin
    pressEdge = (state == DB_RELEASED) && (stateNext == DB_PRESSED);
  end

  assign press = pressQ;

endmodule

// File: rtl/credit_manager_mp.sv
// -----------------------------------------------------------------------------
// credit_manager_mp
// Multi-slot coin-to-credit manager. Each coin input is debounced, pending
// coins are serviced one per cycle in slot-index order, coins are converted to
// credits at COINS_PER_CREDIT coins per credit (saturating at MAX_CREDITS),
// game starts are charged 1 or 2 credits, and a row of credit icons is drawn.
//
// Optional build macro FREE_PLAY_EN: when defined, freePlay=1 grants every
// start request without charging credits. When undefined, freePlay is ignored.
//
// Start handshake: startReq is a one-cycle request, only considered while
// standBy=1. Exactly one of startAck / startDenied pulses on the following
// cycle for each considered request; requests with standBy=0 get no answer.
//
// Ports:
//   clk, resetN        clock, synchronous active-low reset
//   pixelX, pixelY     current pixel coordinate
//   keyCoinN           raw active-low coin switches, one per slot
//   standBy            attract/start screen active
//   startReq           one-cycle game-start request
//   playerMode         0 = 1P (cost 1), 1 = 2P (cost 2), sampled with startReq
//   freePlay           free-play switch (FREE_PLAY_EN builds only)
//   credits            current credit count
//   startAck           start granted pulse
//   startDenied        start refused pulse
//   coinRejected       coin discarded at saturation pulse
//   creditDR           drawing request (1-cycle latency from pixel inputs)
//   creditRGB          pixel colour
// -----------------------------------------------------------------------------
module credit_manager_mp
  import credit_pkg::*;
#(
  parameter int               NUM_SLOTS        = 2,
  parameter int               MAX_CREDITS      = 9,
  parameter int               COINS_PER_CREDIT = 1,
  parameter int               DEBOUNCE_CYCLES  = 16,
  parameter logic [10:0]      TOP_LEFT_X       = 11'd440,
  parameter logic [10:0]      TOP_LEFT_Y       = 11'd450,
  parameter int               ICON_W           = 16,
  parameter int               ICON_H           = 16,
  parameter logic [RGB_W-1:0] ICON_COLOR       = 8'd91
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic [10:0]          pixelX,
  input  logic [10:0]          pixelY,
  input  logic [NUM_SLOTS-1:0] keyCoinN,
  input  logic                 standBy,
  input  logic                 startReq,
  input  logic                 playerMode,
  input  logic                 freePlay,
  output logic [CREDIT_W-1:0]  credits,
  output logic                 startAck,
  output logic                 startDenied,
  output logic                 coinRejected,
  output logic                 creditDR,
  output logic [RGB_W-1:0]     creditRGB
);

  localparam logic [CREDIT_W-1:0] MAX_CR     = CREDIT_W'(MAX_CREDITS);
  localparam logic [2:0]          FRAC_TOP   = 3'(COINS_PER_CREDIT);
  localparam int                  ICON_SHIFT = $clog2(ICON_W);
  localparam logic [11:0]         X_END      = {1'b0, TOP_LEFT_X} + 12'(MAX_CREDITS * ICON_W);
  localparam logic [11:0]         Y_END      = {1'b0, TOP_LEFT_Y} + 12'(ICON_H);

  // ---------------------------------------------------------------------------
  // Debouncers
  // ---------------------------------------------------------------------------
  logic [NUM_SLOTS-1:0] pressVec;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : gSlot
    coin_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uDeb (
      .clk   (clk),
      .resetN(resetN),
      .keyN  (keyCoinN[i]),
      .press (pressVec[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Arbiter: fresh presses join the latched pending set in the same cycle, and
  // the lowest-index request is granted (two's-complement isolate-lowest-bit).
  // ---------------------------------------------------------------------------
  logic [NUM_SLOTS-1:0] pending, req, grant;
  logic                 coinValid;

  assign req       = pending | pressVec;
  assign grant     = req & (~req + NUM_SLOTS'(1));
  assign coinValid = |grant;

  // ---------------------------------------------------------------------------
  // Start / coin accounting
  // ---------------------------------------------------------------------------
  logic                startValid, freeGrant;
  logic [CREDIT_W-1:0] cost, afterCharge, creditsNext;
  logic [2:0]          frac, fracNext, fracInc;
  logic                affordable, doCharge;
  logic                ackNext, denyNext, rejectNext;

  assign startValid = startReq & standBy;

`ifdef FREE_PLAY_EN
  assign freeGrant = startValid & freePlay;
`else
  logic unusedFreePlay;
  assign unusedFreePlay = freePlay;
  assign freeGrant      = 1'b0;
`endif

  // Affordability uses the pre-update count; the coin is then applied on top
  // of the post-charge value, so saturation is judged after the subtraction.
  always_comb begin
    cost        = startCost(player_mode_t'(playerMode));
    affordable  = (credits >= cost);
    doCharge    = startValid & affordable & ~freeGrant;
    afterCharge = doCharge ? (credits - cost) : credits;
    creditsNext = afterCharge;
    fracNext    = frac;
    fracInc     = frac + 3'd1;
    rejectNext  = 1'b0;
    if (coinValid) begin
      if (afterCharge >= MAX_CR) begin
        rejectNext = 1'b1;
      end else if (fracInc == FRAC_TOP) begin
        fracNext    = '0;
        creditsNext = afterCharge + 1'b1;
      end else begin
        fracNext = fracInc;
      end
    end
    ackNext  = startValid & (affordable | freeGrant);
    denyNext = startValid & ~affordable & ~freeGrant;
  end

  // ---------------------------------------------------------------------------
  // Icon row drawing
  // ---------------------------------------------------------------------------
  logic [10:0] relX, iconIdx, iconCol;
  logic        inX, inY, inGap, hit;

  assign relX    = pixelX - TOP_LEFT_X;
  assign iconIdx = relX >> ICON_SHIFT;
  assign iconCol = relX & 11'(ICON_W - 1);
  assign inX     = ({1'b0, pixelX} >= {1'b0, TOP_LEFT_X}) && ({1'b0, pixelX} < X_END);
  assign inY     = ({1'b0, pixelY} >= {1'b0, TOP_LEFT_Y}) && ({1'b0, pixelY} < Y_END);
  // The last two columns of every icon are left blank as a separator.
  assign inGap   = (iconCol >= 11'(ICON_W - 2));
  assign hit     = inX & inY & ~inGap & (iconIdx < 11'(credits));

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetN) begin
      credits      <= '0;
      frac         <= '0;
      pending      <= '0;
      startAck     <= 1'b0;
      startDenied  <= 1'b0;
      coinRejected <= 1'b0;
      creditDR     <= 1'b0;
      creditRGB    <= '0;
    end else begin
      credits      <= creditsNext;
      frac         <= fracNext;
      pending      <= req & ~grant;
      startAck     <= ackNext;
      startDenied  <= denyNext;
      coinRejected <= rejectNext;
      creditDR     <= hit;
      creditRGB    <= hit ? ICON_COLOR : '0;
    end
  end

endmodule

// File: tb/tb_credit_manager_mp.sv
`timescale 1ns/1ps
module tb_credit_manager_mp;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] pixelX = 11'd0, pixelY = 11'd0;
  logic [1:0]  keyCoinN = 2'b11, keyCoinN1 = 2'b11;
  logic        standBy = 1'b0, startReq = 1'b0, startReq1 = 1'b0;
  logic        playerMode = 1'b0, freePlay = 1'b0;

  logic [3:0] credits, credits1;
  logic       startAck, startDenied, coinRejected, creditDR;
  logic       startAck1, startDenied1, coinRejected1, creditDR1;
  logic [7:0] creditRGB, creditRGB1;

  int total = 0;
  int bad   = 0;
  int rejCnt = 0;
  int r0;

  logic [8:0] exp_q[$];

  // Default build: 1 coin per credit
  credit_manager_mp dut0 (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .keyCoinN(keyCoinN), .standBy(standBy), .startReq(startReq),
    .playerMode(playerMode), .freePlay(freePlay), .credits(credits),
    .startAck(startAck), .startDenied(startDenied), .coinRejected(coinRejected),
    .creditDR(creditDR), .creditRGB(creditRGB)
  );

  // Two coins per credit
  credit_manager_mp #(.COINS_PER_CREDIT(2)) dut1 (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .keyCoinN(keyCoinN1), .standBy(standBy), .startReq(startReq1),
    .playerMode(playerMode), .freePlay(freePlay), .credits(credits1),
    .startAck(startAck1), .startDenied(startDenied1), .coinRejected(coinRejected1),
    .creditDR(creditDR1), .creditRGB(creditRGB1)
  );

  always @(negedge clk) begin
    if (resetN && coinRejected) rejCnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic pixModel(input int x, input int y, input int cr);
    int rx;
    rx = x - 440;
    if (x < 440 || x >= 440 + 9 * 16 || y < 450 || y >= 466) return 1'b0;
    return ((rx % 16) < 14) && ((rx / 16) < cr);
  endfunction

  task automatic popCheck(input string name);
    logic [8:0] e;
    e = exp_q.pop_front();
    check({name, " dr"}, creditDR, e[8]);
    check({name, " rgb"}, creditRGB, e[7:0]);
  endtask

  // Drives one pixel and compares the previous one, one cycle later.
  task automatic pixStep(input logic [10:0] x, input logic [10:0] y, input logic dr, input string name);
    @(negedge clk);
    if (exp_q.size() > 0) popCheck(name);
    pixelX = x;
    pixelY = y;
    exp_q.push_back({dr, dr ? 8'd91 : 8'd0});
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic doReset();
    resetN = 1'b0;
    keyCoinN = 2'b11; keyCoinN1 = 2'b11;
    startReq = 1'b0; startReq1 = 1'b0;
    standBy = 1'b0; playerMode = 1'b0; freePlay = 1'b0;
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic coin(input int d, input int slot, input int hold);
    @(negedge clk);
    if (d == 0) keyCoinN[slot] = 1'b0; else keyCoinN1[slot] = 1'b0;
    repeat (hold) @(negedge clk);
    if (d == 0) keyCoinN[slot] = 1'b1; else keyCoinN1[slot] = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic start(input logic sb, input logic mode, input logic expAck,
                       input logic expDen, input logic [3:0] expCr, input string name);
    @(negedge clk);
    standBy = sb; playerMode = mode; startReq = 1'b1;
    @(negedge clk);
    startReq = 1'b0;
    check({name, " ack"}, startAck, expAck);
    check({name, " denied"}, startDenied, expDen);
    check({name, " credits"}, credits, expCr);
    @(negedge clk);
    check({name, " pulse end"}, {startAck, startDenied}, 2'b00);
  endtask

  // ---------------------------------------------------------------------------
  // Pixel vectors (credits = 2)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic        dr;
  } pix_vec_t;

  pix_vec_t vecs[14];

  initial begin
    vecs[0]  = '{11'd440, 11'd450, 1'b1};  // icon0 first column, top row
    vecs[1]  = '{11'd453, 11'd455, 1'b1};  // icon0 last drawn column
    vecs[2]  = '{11'd454, 11'd455, 1'b0};  // icon0 gap
    vecs[3]  = '{11'd455, 11'd455, 1'b0};  // icon0 gap
    vecs[4]  = '{11'd456, 11'd455, 1'b1};  // icon1 first column
    vecs[5]  = '{11'd469, 11'd460, 1'b1};  // icon1 last drawn column
    vecs[6]  = '{11'd470, 11'd460, 1'b0};  // icon1 gap
    vecs[7]  = '{11'd472, 11'd460, 1'b0};  // icon2 (not earned)
    vecs[8]  = '{11'd439, 11'd455, 1'b0};  // left of region
    vecs[9]  = '{11'd583, 11'd455, 1'b0};  // last column of the row
    vecs[10] = '{11'd441, 11'd449, 1'b0};  // above region
    vecs[11] = '{11'd441, 11'd465, 1'b1};  // bottom row
    vecs[12] = '{11'd441, 11'd466, 1'b0};  // below region
    vecs[13] = '{11'd600, 11'd455, 1'b0};  // right of region
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    pixelX = 11'd440; pixelY = 11'd450;
    doReset();
    check("reset credits", credits, 0);
    check("reset startAck", startAck, 0);
    check("reset startDenied", startDenied, 0);
    check("reset coinRejected", coinRejected, 0);
    check("reset creditDR", creditDR, 0);
    check("reset creditRGB", creditRGB, 0);

    // Three clean presses on slot 0
    r0 = rejCnt;
    repeat (3) coin(0, 0, 20);
    check("three coins credits", credits, 3);
    check("three coins no reject", rejCnt - r0, 0);

    // Glitches and the exact debounce threshold on slot 1
    coin(0, 1, 10);
    check("glitch10 credits", credits, 3);
    coin(0, 1, 15);
    check("press15 credits", credits, 3);
    coin(0, 1, 16);
    check("press16 credits", credits, 4);

    // Reset while a press pulse is pending
    @(negedge clk);
    keyCoinN[0] = 1'b0;
    repeat (16) @(negedge clk);
    resetN = 1'b0;
    keyCoinN[0] = 1'b1;
    @(negedge clk);
    resetN = 1'b1;
    repeat (20) @(negedge clk);
    check("reset drops pending", credits, 0);

    // Fill to 8, then two simultaneous coins at the saturation edge
    repeat (8) coin(0, 0, 20);
    check("eight coins credits", credits, 8);
    r0 = rejCnt;
    @(negedge clk);
    keyCoinN = 2'b00;
    repeat (16) @(negedge clk);
    check("simul before service", credits, 8);
    @(negedge clk);
    check("simul slot0 credits", credits, 9);
    check("simul slot0 no reject", coinRejected, 0);
    @(negedge clk);
    check("simul slot1 credits", credits, 9);
    check("simul slot1 rejected", coinRejected, 1);
    keyCoinN = 2'b11;
    repeat (20) @(negedge clk);
    check("simul reject count", rejCnt - r0, 1);
    coin(0, 0, 20);
    check("coin at max credits", credits, 9);
    check("coin at max reject count", rejCnt - r0, 2);

    // Start handshake
    start(1'b0, 1'b1, 1'b0, 1'b0, 4'd9, "2P standby0");
    start(1'b1, 1'b1, 1'b1, 1'b0, 4'd7, "2P at 9");
    start(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, "2P at 7");
    start(1'b1, 1'b1, 1'b1, 1'b0, 4'd3, "2P at 5");
    start(1'b1, 1'b1, 1'b1, 1'b0, 4'd1, "2P at 3");
    start(1'b1, 1'b1, 1'b0, 1'b1, 4'd1, "2P at 1");
    start(1'b0, 1'b0, 1'b0, 1'b0, 4'd1, "1P standby0");
    start(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, "1P at 1");
    start(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, "1P at 0");
`ifdef FREE_PLAY_EN
    freePlay = 1'b1;
    start(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, "freeplay 1P at 0");
    start(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, "freeplay 2P at 0");
    start(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "freeplay standby0");
    freePlay = 1'b0;
`else
    freePlay = 1'b1;
    start(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, "freeplay ignored");
    freePlay = 1'b0;
`endif

    // Icon row at credits = 2: table vectors then a random scan
    repeat (2) coin(0, 0, 20);
    check("pixel setup credits", credits, 2);
    for (int i = 0; i < 14; i++) begin
      pixStep(vecs[i].x, vecs[i].y, vecs[i].dr, $sformatf("pixvec%0d", i));
    end
    for (int i = 0; i < 60; i++) begin
      int rx, ry;
      rx = $urandom_range(600, 430);
      ry = $urandom_range(470, 445);
      pixStep(11'(rx), 11'(ry), pixModel(rx, ry, 2), $sformatf("pixrnd%0d", i));
    end
    @(negedge clk);
    popCheck("pixlast");

    // Two coins per credit, with a coin landing on a 1P start
    doReset();
    coin(1, 0, 20);
    check("cpc2 one coin", credits1, 0);
    coin(1, 0, 20);
    check("cpc2 two coins", credits1, 1);
    coin(1, 0, 20);
    check("cpc2 three coins", credits1, 1);
    @(negedge clk);
    keyCoinN1[0] = 1'b0;
    repeat (16) @(negedge clk);
    standBy = 1'b1; playerMode = 1'b0; startReq1 = 1'b1;
    @(negedge clk);
    startReq1 = 1'b0;
    check("cpc2 simul ack", startAck1, 1);
    check("cpc2 simul denied", startDenied1, 0);
    check("cpc2 simul credits", credits1, 1);
    keyCoinN1[0] = 1'b1;
    repeat (20) @(negedge clk);
    coin(1, 0, 20);
    check("cpc2 frac cleared", credits1, 1);
    coin(1, 0, 20);
    check("cpc2 next credit", credits1, 2);
    check("cpc2 no reject", coinRejected1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
